batcharger_adc_sequencer: RTL
=============================

Name: batcharger_adc_sequencer

Overview:
- Shares the single 8-bit charger ADC between the battery voltage, current and temperature monitors.
- Grants conversions round-robin among the enabled monitors (vmonen, imonen, tmonen from the charger controller) and drives the analog mux select and ADC start.
- Captures results into the vbat/ibat/tbat registers read by the charger controller.
- Generates vtok once fresh voltage and temperature samples exist.

Parameters:
- DATA_W, 8, ADC result width.
- SETTLE_CYC, 4, mux settling cycles between select change and adc_start (range 1..255).
- TIMEOUT_CYC, 64, max cycles from adc_start to adc_eoc before abort (range 2..255).

Ports:
- clk  input  1  state machine clock.
- rstz  input  1  asynchronous reset, active-high.
- en  input  1  block enable.
- vmonen  input  1  voltage monitor request.
- imonen  input  1  current monitor request.
- tmonen  input  1  temperature monitor request.
- adc_eoc  input  1  ADC end-of-conversion, single-cycle pulse.
- adc_data  input  DATA_W  ADC result, valid when adc_eoc=1.
- adc_sel  output  2  mux channel: 0=V, 1=I, 2=T, 3=none.
- adc_start  output  1  one-cycle conversion start pulse.
- vbat  output  DATA_W  last valid voltage sample.
- ibat  output  DATA_W  last valid current sample.
- tbat  output  DATA_W  last valid temperature sample.
- vtok  output  1  voltage and temperature samples valid.
- busy  output  1  conversion sequence in progress (state != IDLE).
- err_timeout  output  1  sticky: a conversion timed out.

Behaviour:
- Reset (rstz, asynchronous, active-high; clock clk):
  - state=IDLE, adc_sel=3, adc_start=0, busy=0, err_timeout=0, vtok=0.
  - vbat=ibat=tbat=0; valid flags v_ok/i_ok/t_ok=0.
  - rr pointer = V (V has first priority after reset).
- States: IDLE, SELECT, SETTLE, START, CONVERT.
- IDLE → SELECT when en=1 and any monitor enable=1.
- SELECT (1 cycle):
  - Arbiter grants the first enabled channel at or after the rr pointer, order V→I→T→V.
  - adc_sel = grant, registered at exit; the cycle counter is loaded.
  - If no enable is set, go to IDLE with adc_sel=3.
- SETTLE: stay SETTLE_CYC cycles, then START.
- START: adc_start=1 for exactly one cycle; timeout counter cleared; go to CONVERT.
- CONVERT, on adc_eoc=1:
  - If the granted channel's enable is still 1: write adc_data to its register and set its valid flag on the same edge.
  - If the enable has dropped: discard the result and clear the flag.
  - rr pointer = grant+1 (mod 3); go to SELECT.
- CONVERT timeout: counter reaches TIMEOUT_CYC with no eoc → set err_timeout (sticky until reset), leave register and flag unchanged, advance rr pointer, go to SELECT.
- adc_eoc outside CONVERT is ignored.
- Latency, enable to first capture: 1 (SELECT) + SETTLE_CYC + 1 (START) + ADC time. adc_sel is stable from SETTLE entry through CONVERT exit.
- Enable deassert:
  - When a monitor enable falls, its valid flag clears the next cycle. The register value is retained.
- en=0 in any state:
  - Next cycle state=IDLE, adc_start=0, adc_sel=3.
  - All valid flags clear; registers and rr pointer retained.
  - An in-flight eoc is ignored.
- vtok = v_ok & t_ok (registered flags, no extra delay).
- Simultaneous events:
  - eoc and enable falling on the same edge: result discarded.
  - eoc on the timeout-terminal cycle: eoc wins, no error.
- Single enabled channel: it is re-granted every SELECT.

Decomposition:
- Package batcharger_pkg holds:
  - the channel encoding (CH_V=0, CH_I=1, CH_T=2, CH_NONE=3);
  - the sequencer state enum;
  - the DATA_W default.
- Sub-module batcharger_rr_arb3: 3-request round-robin arbiter, purely combinational grant from {req[2:0], ptr} plus a grant_valid output.

Test Plan:
- Reset, then en=1, vmonen=tmonen=1, ADC model returning eoc 10 cycles after start with data 0xA5 (V) / 0x40 (T):
  - adc_sel sequence is 0,2,0,2…;
  - vbat=0xA5 and tbat=0x40;
  - vtok rises on the second capture edge;
  - adc_start pulses are each 1 cycle and fire SETTLE_CYC+1 cycles after SELECT.
- All three enables, data V=0xB0 / I=0x12 / T=0x55:
  - grant order is V,I,T,V;
  - ibat=0x12;
  - no channel is granted twice in a row.
- ADC model never asserts eoc:
  - err_timeout=1 exactly TIMEOUT_CYC cycles after adc_start;
  - vbat is unchanged;
  - the sequencer moves on to the next channel.
- vmonen dropped mid-CONVERT on the V slot, eoc with 0xFF:
  - vbat keeps its old value;
  - v_ok=0 and vtok=0.
- en dropped in SETTLE:
  - next cycle: IDLE, adc_sel=3, vtok=0, registers retained.
  - Re-enabled: the rr pointer resumes from its saved value.
- rstz pulsed during CONVERT: all outputs return to reset values immediately, with no clock needed.

Source files
------------

// File: rtl/batcharger_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : batcharger_pkg
//  Description : Shared encodings for the charger ADC sequencer: mux channel
//                codes, sequencer state codes and the default result width.
//  Revision    : 1.0 - initial release
// ============================================================================
package batcharger_pkg;

   localparam int DATA_W_DEF = 8;

   // Analog mux channel codes, also used as the arbiter grant encoding
   localparam logic [1:0] CH_V    = 2'd0;
   localparam logic [1:0] CH_I    = 2'd1;
   localparam logic [1:0] CH_T    = 2'd2;
   localparam logic [1:0] CH_NONE = 2'd3;

   // Sequencer state codes
   typedef logic [2:0] seq_state_t;
   localparam seq_state_t ST_IDLE    = 3'd0;
   localparam seq_state_t ST_SELECT  = 3'd1;
   localparam seq_state_t ST_SETTLE  = 3'd2;
   localparam seq_state_t ST_START   = 3'd3;
   localparam seq_state_t ST_CONVERT = 3'd4;

   // Next channel in the V -> I -> T -> V rotation
   function automatic logic [1:0] ch_next(input logic [1:0] ch);
      return (ch == CH_T) ? CH_V : (ch + 2'd1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/batcharger_rr_arb3.sv
`default_nettype none
// ============================================================================
//  Module      : batcharger_rr_arb3
//  Description : Three-request round-robin arbiter. Grants the first active
//                request at or after the pointer, rotating V -> I -> T -> V.
//                Purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module batcharger_rr_arb3
   import batcharger_pkg::*;
(
   input  logic [2:0] req_i,
   input  logic [1:0] ptr_i,
   output logic [1:0] grant_o,
   output logic       grant_valid_o
);

   logic [1:0] w_c0;
   logic [1:0] w_c1;
   logic [1:0] w_c2;

   // A pointer of CH_NONE never occurs in practice; treat it as V for safety
   assign w_c0 = (ptr_i == CH_NONE) ? CH_V : ptr_i;
   assign w_c1 = ch_next(w_c0);
   assign w_c2 = ch_next(w_c1);

   // Priority scan over the rotated candidate order
   always_comb begin
      grant_o       = CH_NONE;
      grant_valid_o = 1'b1;
      if (req_i[w_c0]) begin
         grant_o = w_c0;
      end else if (req_i[w_c1]) begin
         grant_o = w_c1;
      end else if (req_i[w_c2]) begin
         grant_o = w_c2;
      end else begin
         grant_valid_o = 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/batcharger_adc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : batcharger_adc_sequencer
//  Description : Time-shares the charger ADC between the voltage, current and
//                temperature monitors. Round-robin grant, mux settling delay,
//                start pulse, result capture with valid flags and a sticky
//                conversion timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module batcharger_adc_sequencer
   import batcharger_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SETTLE_CYC  = 4,    // 1..255
   parameter int TIMEOUT_CYC = 64    // 2..255
) (
   input  logic              clk,
   input  logic              rstz,
   input  logic              en,
   input  logic              vmonen,
   input  logic              imonen,
   input  logic              tmonen,
   input  logic              adc_eoc,
   input  logic [DATA_W-1:0] adc_data,
   output logic [1:0]        adc_sel,
   output logic              adc_start,
   output logic [DATA_W-1:0] vbat,
   output logic [DATA_W-1:0] ibat,
   output logic [DATA_W-1:0] tbat,
   output logic              vtok,
   output logic              busy,
   output logic              err_timeout
);

   localparam logic [7:0] c_SETTLE  = 8'(SETTLE_CYC);
   // The counter is cleared in START and counts CONVERT cycles from zero, so
   // the abort decision on this value makes err_timeout visible exactly
   // TIMEOUT_CYC cycles after the adc_start pulse.
   localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYC - 2);

   seq_state_t        state_q, state_d;
   logic [1:0]        sel_q, sel_d;
   logic              start_q, start_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [2:0]        ok_q, ok_d;       // [0]=V, [1]=I, [2]=T
   logic              err_q, err_d;
   logic [DATA_W-1:0] vbat_q, vbat_d;
   logic [DATA_W-1:0] ibat_q, ibat_d;
   logic [DATA_W-1:0] tbat_q, tbat_d;

   logic [2:0]        w_req;
   logic [1:0]        w_grant;
   logic              w_grant_valid;

   assign w_req = {tmonen, imonen, vmonen};

   batcharger_rr_arb3 u_arb (
      .req_i         (w_req),
      .ptr_i         (ptr_q),
      .grant_o       (w_grant),
      .grant_valid_o (w_grant_valid)
   );

   // Next-state logic for the sequencer, capture registers and flags
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      start_d = 1'b0;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      ok_d    = ok_q & w_req;   // a flag drops the cycle after its enable falls
      err_d   = err_q;
      vbat_d  = vbat_q;
      ibat_d  = ibat_q;
      tbat_d  = tbat_q;

      if (!en) begin
         // Block disable aborts everything; results and pointer survive
         state_d = ST_IDLE;
         sel_d   = CH_NONE;
         ok_d    = 3'b000;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|w_req) begin
                  state_d = ST_SELECT;
               end
            end
            ST_SELECT: begin
               if (w_grant_valid) begin
                  sel_d   = w_grant;
                  cnt_d   = c_SETTLE;
                  state_d = ST_SETTLE;
               end else begin
                  sel_d   = CH_NONE;
                  state_d = ST_IDLE;
               end
            end
            ST_SETTLE: begin
               if (cnt_q <= 8'd1) begin
                  start_d = 1'b1;
                  state_d = ST_START;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            ST_START: begin
               cnt_d   = 8'd0;
               state_d = ST_CONVERT;
            end
            ST_CONVERT: begin
               // eoc takes precedence over a coincident timeout
               if (adc_eoc) begin
                  case (sel_q)
                     CH_V: if (vmonen) begin vbat_d = adc_data; ok_d[0] = 1'b1; end
                     CH_I: if (imonen) begin ibat_d = adc_data; ok_d[1] = 1'b1; end
                     CH_T: if (tmonen) begin tbat_d = adc_data; ok_d[2] = 1'b1; end
                     default: ;
                  endcase
                  ptr_d   = ch_next(sel_q);
                  state_d = ST_SELECT;
               end else if (cnt_q == c_TO_LAST) begin
                  err_d   = 1'b1;
                  ptr_d   = ch_next(sel_q);
                  state_d = ST_SELECT;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               sel_d   = CH_NONE;
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous reset
   always_ff @(posedge clk or posedge rstz) begin
      if (rstz) begin
         state_q <= ST_IDLE;
         sel_q   <= CH_NONE;
         start_q <= 1'b0;
         cnt_q   <= 8'd0;
         ptr_q   <= CH_V;
         ok_q    <= 3'b000;
         err_q   <= 1'b0;
         vbat_q  <= '0;
         ibat_q  <= '0;
         tbat_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         start_q <= start_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
         vbat_q  <= vbat_d;
         ibat_q  <= ibat_d;
         tbat_q  <= tbat_d;
      end
   end

   assign adc_sel     = sel_q;
   assign adc_start   = start_q;
   assign vbat        = vbat_q;
   assign ibat        = ibat_q;
   assign tbat        = tbat_q;
   assign vtok        = ok_q[0] & ok_q[2];
   assign busy        = (state_q != ST_IDLE);
   assign err_timeout = err_q;

endmodule
`default_nettype wire
